bus_server_responder: RTL and testbench
=======================================

Name: bus_server_responder

Overview:
- Server-side responder of the 4-client bus arbiter. It consumes the arbiter's selected address, captures the selected client's data word and occupies the bus for a fixed service time.
- It then returns a one-cycle server_ack that advances the arbiter's ring, plus a per-client done strobe.
- Sits between the round-robin arbitration logic and the downstream data sink.

Parameters:
- DATA_WIDTH, 8: width of each client data word and of served_data.
- SERVICE_CYCLES, 3: cycles spent in SERVE per transaction; legal range 1..255.
- COUNT_WIDTH, 16: width of the transaction counter.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  permits acceptance of new transactions.
- request_valid  input  1  at least one client request pending; address_to_be_served is meaningful.
- address_to_be_served  input  2  arbiter-selected client (00=client 1 .. 11=client 4).
- client_1_data .. client_4_data  input  DATA_WIDTH each  per-client data words.
- server_ack  output  1  one-cycle completion pulse back to the arbiter.
- client_1_done .. client_4_done  output  1 each  one-cycle done strobe to the served client.
- served_data  output  DATA_WIDTH  captured data word.
- served_data_valid  output  1  served_data qualifier, coincident with server_ack.
- served_address  output  2  latched address of the current or last transaction.
- busy  output  1  high in SERVE and ACK.
- transaction_count  output  COUNT_WIDTH  number of completed transactions.

Behaviour:
- All outputs are registered. While reset is low: FSM=IDLE; all outputs, the counter and the capture registers are 0.
- FSM states: IDLE, SERVE, ACK.
- IDLE:
  - If enable=1 and request_valid=1 at a rising edge: latch address_to_be_served into served_address, latch the matching client_N_data into the capture register, load the service counter with SERVICE_CYCLES-1, go to SERVE.
  - Otherwise stay in IDLE.
- SERVE:
  - busy=1; the counter decrements each cycle.
  - When the counter is 0, go to ACK.
  - Dwell is exactly SERVICE_CYCLES cycles; SERVICE_CYCLES=1 gives one cycle.
- ACK (exactly one cycle):
  - server_ack=1, served_data_valid=1, and client_N_done=1 only for N = served_address+1.
  - served_data holds the captured word. transaction_count increments and wraps to 0 at all-ones.
  - Next state is always IDLE.
- Latency: if accepted at edge E, server_ack is high during the cycle following edge E+SERVICE_CYCLES.
- The mandatory IDLE cycle after ACK gives the arbiter one cycle to rotate. Back-to-back throughput is one transaction per SERVICE_CYCLES+2 cycles.
- Changes on address, data or request_valid after capture are ignored until the next IDLE acceptance.
- enable falling during SERVE or ACK: the current transaction completes normally; no new acceptance occurs.
- request_valid falling mid-transaction: the transaction still completes and acks.
- served_data and served_address hold their values after ACK until the next capture. served_data_valid and the done strobes are 0 outside ACK.
- Reset asserted mid-transaction: immediate return to IDLE; no ack or done is emitted; transaction_count clears.
- Exactly one done strobe is high per ACK; server_ack=1 if and only if any done strobe is 1.

Decomposition:
- Shared package/header: FSM state encodings (IDLE=2'b00, SERVE=2'b01, ACK=2'b10) and the channel address constants 2'b00..2'b11. Both are shared with the arbiter logic.
- One natural sub-module, client_data_mux: a combinational 4:1 DATA_WIDTH mux selected by address. Everything else stays in bus_server_responder.

Test Plan:
- Single request, reset-to-idle: reset low 3 cycles, then enable=1, request_valid=1, address=2'b10, client_3_data=8'hA5, SERVICE_CYCLES=3 → busy rises the cycle after acceptance. server_ack, served_data_valid and client_3_done pulse for 1 cycle, 4 cycles after acceptance. served_data=8'hA5, transaction_count=1.
- Back-to-back: request_valid held high, addresses 00,01,10,11 presented in turn → acks are spaced exactly 5 cycles apart. Done strobes go 1,2,3,4; transaction_count=4.
- Capture stability: accept address=2'b00 with data 8'h11, then change to address=2'b11 and data 8'hFF during SERVE → client_1_done only, served_data=8'h11.
- Enable gating: drop enable during SERVE → the current ack still occurs, then the block stays in IDLE with busy=0 despite request_valid=1. Re-enable → acceptance on the next edge.
- Reset mid-service: assert reset in the second SERVE cycle → no server_ack, all outputs 0 immediately; after release, a new request completes normally.
- Boundary: SERVICE_CYCLES=1 → ack in the second cycle after acceptance. With COUNT_WIDTH=2, the fourth completion wraps transaction_count from 3 to 0.

Source files
------------

// File: rtl/bus_server_responder_pkg.sv
// Shared definitions for the bus server responder: FSM encodings and client
// channel addresses, also used by the arbiter logic.
package bus_server_responder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SERVE = 2'b01,
      ST_ACK   = 2'b10
   } state_e;

   localparam logic [1:0] ADDR_CLIENT_1 = 2'b00;
   localparam logic [1:0] ADDR_CLIENT_2 = 2'b01;
   localparam logic [1:0] ADDR_CLIENT_3 = 2'b10;
   localparam logic [1:0] ADDR_CLIENT_4 = 2'b11;

   localparam int SVC_CNT_W = 8;

   // One-hot done vector {client_4 .. client_1} for a channel address.
   function automatic logic [3:0] client_onehot(input logic [1:0] addr);
      logic [3:0] vec;
      case (addr)
         ADDR_CLIENT_1: vec = 4'b0001;
         ADDR_CLIENT_2: vec = 4'b0010;
         ADDR_CLIENT_3: vec = 4'b0100;
         ADDR_CLIENT_4: vec = 4'b1000;
         default:       vec = 4'b0000;
      endcase
      return vec;
   endfunction

endpackage

// File: rtl/bus_server_responder_client_data_mux.sv
// Combinational 4:1 selector of the client data word addressed by the arbiter.
module client_data_mux
   import bus_server_responder_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic [1:0]            sel,
   input  logic [DATA_WIDTH-1:0] client_1_data,
   input  logic [DATA_WIDTH-1:0] client_2_data,
   input  logic [DATA_WIDTH-1:0] client_3_data,
   input  logic [DATA_WIDTH-1:0] client_4_data,
   output logic [DATA_WIDTH-1:0] data_out
);

   // Select the addressed client's word.
   always_comb begin
      data_out = {DATA_WIDTH{1'b0}};
      case (sel)
         ADDR_CLIENT_1: data_out = client_1_data;
         ADDR_CLIENT_2: data_out = client_2_data;
         ADDR_CLIENT_3: data_out = client_3_data;
         ADDR_CLIENT_4: data_out = client_4_data;
         default:       data_out = {DATA_WIDTH{1'b0}};
      endcase
   end

endmodule

// File: rtl/bus_server_responder.sv
// Server-side responder: captures the arbiter-selected client word, holds the
// bus for SERVICE_CYCLES cycles, then pulses server_ack and the client's done.
module bus_server_responder
   import bus_server_responder_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int SERVICE_CYCLES = 3,
   parameter int COUNT_WIDTH    = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   input  logic                   request_valid,
   input  logic [1:0]             address_to_be_served,
   input  logic [DATA_WIDTH-1:0]  client_1_data,
   input  logic [DATA_WIDTH-1:0]  client_2_data,
   input  logic [DATA_WIDTH-1:0]  client_3_data,
   input  logic [DATA_WIDTH-1:0]  client_4_data,
   output logic                   server_ack,
   output logic                   client_1_done,
   output logic                   client_2_done,
   output logic                   client_3_done,
   output logic                   client_4_done,
   output logic [DATA_WIDTH-1:0]  served_data,
   output logic                   served_data_valid,
   output logic [1:0]             served_address,
   output logic                   busy,
   output logic [COUNT_WIDTH-1:0] transaction_count
);

   localparam logic [SVC_CNT_W-1:0] SVC_LOAD = SVC_CNT_W'(SERVICE_CYCLES - 1);

   state_e                 state_q, state_d;
   logic [SVC_CNT_W-1:0]   svc_cnt_q, svc_cnt_d;
   logic [DATA_WIDTH-1:0]  served_data_q, served_data_d;
   logic [1:0]             served_address_q, served_address_d;
   logic                   busy_q, busy_d;
   logic                   server_ack_q, server_ack_d;
   logic                   valid_q, valid_d;
   logic [3:0]             done_q, done_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;
   logic [DATA_WIDTH-1:0]  mux_data_s;

   client_data_mux #(.DATA_WIDTH(DATA_WIDTH)) u_client_data_mux (
      .sel           (address_to_be_served),
      .client_1_data (client_1_data),
      .client_2_data (client_2_data),
      .client_3_data (client_3_data),
      .client_4_data (client_4_data),
      .data_out      (mux_data_s)
   );

   // Next-state and next-output logic; strobes are computed one cycle ahead
   // so that every output comes straight from a flop.
   always_comb begin
      state_d          = state_q;
      svc_cnt_d        = svc_cnt_q;
      served_data_d    = served_data_q;
      served_address_d = served_address_q;
      server_ack_d     = 1'b0;
      valid_d          = 1'b0;
      done_d           = 4'b0000;
      count_d          = count_q;
      case (state_q)
         ST_IDLE: begin
            if (enable && request_valid) begin
               state_d          = ST_SERVE;
               served_address_d = address_to_be_served;
               served_data_d    = mux_data_s;
               svc_cnt_d        = SVC_LOAD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SERVE: begin
            if (svc_cnt_q == {SVC_CNT_W{1'b0}}) begin
               state_d      = ST_ACK;
               server_ack_d = 1'b1;
               valid_d      = 1'b1;
               done_d       = client_onehot(served_address_q);
               count_d      = count_q + COUNT_WIDTH'(1);
            end else begin
               svc_cnt_d = svc_cnt_q - SVC_CNT_W'(1);
            end
         end
         ST_ACK: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d == ST_SERVE) || (state_d == ST_ACK);
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q          <= ST_IDLE;
         svc_cnt_q        <= {SVC_CNT_W{1'b0}};
         served_data_q    <= {DATA_WIDTH{1'b0}};
         served_address_q <= 2'b00;
         busy_q           <= 1'b0;
         server_ack_q     <= 1'b0;
         valid_q          <= 1'b0;
         done_q           <= 4'b0000;
         count_q          <= {COUNT_WIDTH{1'b0}};
      end else begin
         state_q          <= state_d;
         svc_cnt_q        <= svc_cnt_d;
         served_data_q    <= served_data_d;
         served_address_q <= served_address_d;
         busy_q           <= busy_d;
         server_ack_q     <= server_ack_d;
         valid_q          <= valid_d;
         done_q           <= done_d;
         count_q          <= count_d;
      end
   end

   assign server_ack        = server_ack_q;
   assign served_data_valid = valid_q;
   assign client_1_done     = done_q[0];
   assign client_2_done     = done_q[1];
   assign client_3_done     = done_q[2];
   assign client_4_done     = done_q[3];
   assign served_data       = served_data_q;
   assign served_address    = served_address_q;
   assign busy              = busy_q;
   assign transaction_count = count_q;

endmodule

// File: tb/tb_bus_server_responder.sv
// Bench for bus_server_responder: two instances (3-cycle/16-bit count and
// 1-cycle/2-bit count) checked every cycle against a transaction-level model.
module tb_bus_server_responder;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic       request_valid;
   logic [1:0] addr;
   logic [7:0] c1, c2, c3, c4;

   wire        ack0, valid0, busy0, ack1, valid1, busy1;
   wire [3:0]  done0, done1;
   wire [7:0]  sd0, sd1;
   wire [1:0]  sa0, sa1;
   wire [15:0] tc0;
   wire [1:0]  tc1;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Model state per instance: time of last acceptance, earliest next
   // acceptance, captured word/address and completed-transaction count.
   int         sc[2]   = '{3, 1};
   int         mask[2] = '{32'h0000_FFFF, 32'h0000_0003};
   bit         act[2];
   int         acc_e[2];
   int         free_at[2];
   int         tc[2];
   logic [7:0] cap_d[2];
   logic [1:0] cap_a[2];
   int         ack_cycs[$];

   always #5 clk = ~clk;

   bus_server_responder #(.DATA_WIDTH(8), .SERVICE_CYCLES(3), .COUNT_WIDTH(16)) dut0 (
      .clk(clk), .reset(reset), .enable(enable), .request_valid(request_valid),
      .address_to_be_served(addr),
      .client_1_data(c1), .client_2_data(c2), .client_3_data(c3), .client_4_data(c4),
      .server_ack(ack0),
      .client_1_done(done0[0]), .client_2_done(done0[1]),
      .client_3_done(done0[2]), .client_4_done(done0[3]),
      .served_data(sd0), .served_data_valid(valid0), .served_address(sa0),
      .busy(busy0), .transaction_count(tc0)
   );

   bus_server_responder #(.DATA_WIDTH(8), .SERVICE_CYCLES(1), .COUNT_WIDTH(2)) dut1 (
      .clk(clk), .reset(reset), .enable(enable), .request_valid(request_valid),
      .address_to_be_served(addr),
      .client_1_data(c1), .client_2_data(c2), .client_3_data(c3), .client_4_data(c4),
      .server_ack(ack1),
      .client_1_done(done1[0]), .client_2_done(done1[1]),
      .client_3_done(done1[2]), .client_4_done(done1[3]),
      .served_data(sd1), .served_data_valid(valid1), .served_address(sa1),
      .busy(busy1), .transaction_count(tc1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h (cyc %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_reset(input int d);
      act[d]     = 1'b0;
      acc_e[d]   = 0;
      free_at[d] = 0;
      tc[d]      = 0;
      cap_d[d]   = 8'h00;
      cap_a[d]   = 2'b00;
   endtask

   function automatic logic [7:0] pick(input logic [1:0] a);
      logic [7:0] words [4];
      words[0] = c1; words[1] = c2; words[2] = c3; words[3] = c4;
      return words[a];
   endfunction

   // Accepted at edge E: busy after edges E..E+SC, ack after edge E+SC,
   // next acceptance no earlier than edge E+SC+2.
   task automatic model_edge(input int d);
      if (!reset) begin
         model_reset(d);
      end else begin
         if (act[d] && cyc == acc_e[d] + sc[d]) tc[d] = (tc[d] + 1) & mask[d];
         if (cyc >= free_at[d] && enable && request_valid) begin
            act[d]     = 1'b1;
            acc_e[d]   = cyc;
            free_at[d] = cyc + sc[d] + 2;
            cap_a[d]   = addr;
            cap_d[d]   = pick(addr);
         end
      end
   endtask

   task automatic check_dut(input int d);
      logic        ao, vo, bo, ack_e, busy_e;
      logic [3:0]  dno, done_e;
      logic [7:0]  so;
      logic [1:0]  sao;
      logic [31:0] tco;
      if (d == 0) begin
         ao = ack0; vo = valid0; bo = busy0; dno = done0; so = sd0; sao = sa0; tco = 32'(tc0);
      end else begin
         ao = ack1; vo = valid1; bo = busy1; dno = done1; so = sd1; sao = sa1; tco = 32'(tc1);
      end
      ack_e  = act[d] && (cyc == acc_e[d] + sc[d]);
      busy_e = act[d] && (cyc >= acc_e[d]) && (cyc <= acc_e[d] + sc[d]);
      done_e = ack_e ? (4'b0001 << cap_a[d]) : 4'b0000;
      chk($sformatf("d%0d server_ack", d), 32'(ao), 32'(ack_e));
      chk($sformatf("d%0d valid", d), 32'(vo), 32'(ack_e));
      chk($sformatf("d%0d busy", d), 32'(bo), 32'(busy_e));
      chk($sformatf("d%0d done", d), 32'(dno), 32'(done_e));
      chk($sformatf("d%0d served_data", d), 32'(so), 32'(cap_d[d]));
      chk($sformatf("d%0d served_address", d), 32'(sao), 32'(cap_a[d]));
      chk($sformatf("d%0d count", d), tco, 32'(tc[d]));
   endtask

   task automatic step();
      @(posedge clk);
      cyc++;
      model_edge(0);
      model_edge(1);
      @(negedge clk);
      check_dut(0);
      check_dut(1);
      if (ack0 === 1'b1) ack_cycs.push_back(cyc);
   endtask

   task automatic wait_accept0(input string tag);
      int n = 0;
      do begin
         step();
         n++;
      end while (!(act[0] && acc_e[0] == cyc) && n < 20);
      chk({tag, " accept timeout"}, 32'(n < 20), 32'd1);
   endtask

   initial begin
      int n;
      int seen1;
      reset = 1'b0; enable = 1'b0; request_valid = 1'b0; addr = 2'b00;
      c1 = 8'h00; c2 = 8'h00; c3 = 8'h00; c4 = 8'h00;
      model_reset(0);
      model_reset(1);
      #1;
      check_dut(0);
      check_dut(1);
      repeat (3) step();

      // Single request to client 3.
      reset = 1'b1; enable = 1'b1; request_valid = 1'b1; addr = 2'b10; c3 = 8'hA5;
      step();
      request_valid = 1'b0;
      repeat (5) step();
      chk("t1 count", 32'(tc0), 32'd1);
      chk("t1 data", 32'(sd0), 32'h0000_00A5);

      // Back-to-back over all four clients.
      c1 = 8'h01; c2 = 8'h02; c4 = 8'h04;
      ack_cycs.delete();
      request_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         addr = 2'(i);
         wait_accept0("b2b");
      end
      request_valid = 1'b0;
      repeat (6) step();
      chk("b2b acks", 32'(ack_cycs.size()), 32'd4);
      for (int i = 1; i < ack_cycs.size(); i++)
         chk("b2b spacing", 32'(ack_cycs[i] - ack_cycs[i-1]), 32'd5);
      chk("b2b count", 32'(tc0), 32'd5);

      // Capture stability.
      addr = 2'b00; c1 = 8'h11; request_valid = 1'b1;
      wait_accept0("cap");
      request_valid = 1'b0; addr = 2'b11; c1 = 8'hFF; c4 = 8'hFF;
      repeat (5) step();
      chk("cap data", 32'(sd0), 32'h0000_0011);
      chk("cap addr", 32'(sa0), 32'd0);

      // Enable gating.
      request_valid = 1'b1; addr = 2'b01; c2 = 8'h3C;
      wait_accept0("en");
      step();
      enable = 1'b0;
      repeat (8) step();
      chk("en idle busy", 32'(busy0), 32'd0);
      enable = 1'b1;
      step();
      chk("en reaccept busy", 32'(busy0), 32'd1);
      request_valid = 1'b0;
      repeat (6) step();

      // Reset in the second SERVE cycle.
      request_valid = 1'b1; addr = 2'b11; c4 = 8'h77;
      wait_accept0("rst");
      step();
      reset = 1'b0;
      #1;
      model_reset(0);
      model_reset(1);
      check_dut(0);
      check_dut(1);
      repeat (2) step();
      reset = 1'b1; addr = 2'b01; c2 = 8'h5A;
      wait_accept0("post rst");
      request_valid = 1'b0;
      repeat (5) step();
      chk("post rst count", 32'(tc0), 32'd1);
      chk("post rst data", 32'(sd0), 32'h0000_005A);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 400; i++) begin
         enable        = ($urandom_range(0, 3) != 0);
         request_valid = ($urandom_range(0, 9) < 6);
         addr          = 2'($urandom_range(0, 3));
         c1 = 8'($urandom); c2 = 8'($urandom); c3 = 8'($urandom); c4 = 8'($urandom);
         reset = ($urandom_range(0, 99) != 0);
         if (!reset) begin
            #1;
            model_reset(0);
            model_reset(1);
            check_dut(0);
            check_dut(1);
         end
         step();
      end

      // Two-bit counter wrap on the single-cycle instance.
      reset = 1'b0;
      step();
      reset = 1'b1; enable = 1'b1; request_valid = 1'b1; addr = 2'b10;
      seen1 = 0;
      n = 0;
      while (seen1 < 4 && n < 60) begin
         step();
         n++;
         if (ack1 === 1'b1) seen1++;
      end
      chk("wrap timeout", 32'(seen1), 32'd4);
      chk("wrap count", 32'(tc1), 32'd0);
      request_valid = 1'b0;
      repeat (5) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
